// File: rtl/usb3_tp_arbiter.sv
// usb3_tp_arbiter: round-robin sharing of the link TP transmit port between
// data-ACK (A), status-ACK (B) and NRDY/ERDY (C) sources, with stall abort and sticky errors.
module usb3_tp_arbiter #(
    parameter logic [9:0] TIMEOUT = 10'd1023,
    parameter logic [9:0] HOLDOFF = 10'd2
) (
    input  logic        local_clk,
    input  logic        reset,
    input  logic        link_ready,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        req_c,
    input  logic [35:0] hdr_a,
    input  logic [35:0] hdr_b,
    input  logic [35:0] hdr_c,
    output logic        ack_a,
    output logic        ack_b,
    output logic        ack_c,
    output logic        tx_tp,
    output logic        tx_tp_retry,
    output logic        tx_tp_dir,
    output logic [3:0]  tx_tp_subtype,
    output logic [3:0]  tx_tp_endp,
    output logic [4:0]  tx_tp_nump,
    output logic [4:0]  tx_tp_seq,
    output logic [15:0] tx_tp_stream,
    input  logic        tx_tp_ack,
    output logic [1:0]  grant_id,
    output logic        err_timeout,
    output logic        err_drop
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_last;
    logic [1:0]  r_gid;
    logic [9:0]  r_cnt;
    logic [9:0]  r_gap;
    logic [35:0] r_hdr;
    logic [2:0]  r_ack;
    logic        r_tx;
    logic        r_err_to;
    logic        r_err_drop;
    logic [3:0]  w_req;
    logic [1:0]  w_n1;
    logic [1:0]  w_n2;
    logic [1:0]  w_win;
    logic [35:0] w_hdr;

    // Bit 3 pads the request vector so index 3 ("none") always reads as idle.
    assign w_req = {1'b0, req_c, req_b, req_a};

    always_comb begin
        w_n1  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_n2  = (w_n1 == 2'd2) ? 2'd0 : w_n1 + 2'd1;
        w_win = w_req[w_n1] ? w_n1 : w_req[w_n2] ? w_n2 : w_req[r_last] ? r_last : 2'd3;
        w_hdr = (w_win == 2'd0) ? hdr_a : (w_win == 2'd1) ? hdr_b : hdr_c;
    end

    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last     <= 2'd2;
            r_gid      <= 2'd3;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_hdr      <= '0;
            r_ack      <= '0;
            r_tx       <= 1'b0;
            r_err_to   <= 1'b0;
            r_err_drop <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (link_ready && w_win != 2'd3) begin
                        r_hdr   <= w_hdr;
                        r_tx    <= 1'b1;
                        r_gid   <= w_win;
                        r_cnt   <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A link ack takes precedence over a coincident timeout or link drop.
                    if (tx_tp_ack) begin
                        r_tx    <= 1'b0;
                        r_ack   <= {r_gid == 2'd2, r_gid == 2'd1, r_gid == 2'd0};
                        r_last  <= r_gid;
                        r_gid   <= 2'd3;
                        r_gap   <= HOLDOFF;
                        r_state <= S_GAP;
                    end else if (r_cnt == TIMEOUT - 10'd1 || !link_ready) begin
                        r_tx     <= 1'b0;
                        r_err_to <= 1'b1;
                        if (!link_ready) r_err_drop <= 1'b1;
                        r_last   <= r_gid;
                        r_gid    <= 2'd3;
                        r_gap    <= HOLDOFF;
                        r_state  <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap <= 10'd1) r_state <= S_IDLE;
                    else r_gap <= r_gap - 10'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_tp         = r_tx;
    assign tx_tp_retry   = r_hdr[35];
    assign tx_tp_dir     = r_hdr[34];
    assign tx_tp_subtype = r_hdr[33:30];
    assign tx_tp_endp    = r_hdr[29:26];
    assign tx_tp_nump    = r_hdr[25:21];
    assign tx_tp_seq     = r_hdr[20:16];
    assign tx_tp_stream  = r_hdr[15:0];
    assign {ack_c, ack_b, ack_a} = r_ack;
    assign grant_id      = r_gid;
    assign err_timeout   = r_err_to;
    assign err_drop      = r_err_drop;
endmodule

// File: tb/tb_usb3_tp_arbiter.sv
// tb_usb3_tp_arbiter: scoreboard bench; expected grants are queued as requests are
// driven and checked by a monitor whenever tx_tp rises.
module tb_usb3_tp_arbiter;
    logic        local_clk = 1'b0;
    logic        reset = 1'b1;
    logic        link_ready = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
    logic [35:0] hdr_a = '0, hdr_b = '0, hdr_c = '0;
    logic        ack_a, ack_b, ack_c;
    logic        tx_tp, tx_tp_retry, tx_tp_dir;
    logic [3:0]  tx_tp_subtype, tx_tp_endp;
    logic [4:0]  tx_tp_nump, tx_tp_seq;
    logic [15:0] tx_tp_stream;
    logic        tx_tp_ack = 1'b0;
    logic [1:0]  grant_id;
    logic        err_timeout, err_drop;

    typedef struct {
        logic [1:0]  id;
        logic [35:0] hdr;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail = 0;
    int n_acks = 0;
    int n;

    logic [35:0] tx_hdr;
    logic [2:0]  acks;
    logic [2:0]  prev_ack = '0;
    logic        prev_tx = 1'b0;
    logic [1:0]  last_id = 2'd3;

    localparam logic [35:0] HA = {1'b0, 1'b1, 4'd1, 4'd2, 5'd1, 5'd5, 16'hA5C3};
    localparam logic [35:0] HB = {1'b1, 1'b0, 4'd2, 4'd7, 5'd0, 5'd17, 16'h1234};
    localparam logic [35:0] HC = {1'b0, 1'b0, 4'd3, 4'd15, 5'd31, 5'd9, 16'hFEED};

    assign tx_hdr = {tx_tp_retry, tx_tp_dir, tx_tp_subtype, tx_tp_endp, tx_tp_nump, tx_tp_seq, tx_tp_stream};
    assign acks   = {ack_c, ack_b, ack_a};

    usb3_tp_arbiter dut (
        .local_clk(local_clk), .reset(reset), .link_ready(link_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .hdr_a(hdr_a), .hdr_b(hdr_b), .hdr_c(hdr_c),
        .ack_a(ack_a), .ack_b(ack_b), .ack_c(ack_c),
        .tx_tp(tx_tp), .tx_tp_retry(tx_tp_retry), .tx_tp_dir(tx_tp_dir),
        .tx_tp_subtype(tx_tp_subtype), .tx_tp_endp(tx_tp_endp),
        .tx_tp_nump(tx_tp_nump), .tx_tp_seq(tx_tp_seq), .tx_tp_stream(tx_tp_stream),
        .tx_tp_ack(tx_tp_ack), .grant_id(grant_id),
        .err_timeout(err_timeout), .err_drop(err_drop)
    );

    always #5 local_clk = ~local_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge local_clk) begin
        if (reset) begin
            prev_tx  = 1'b0;
            prev_ack = '0;
        end else begin
            if (tx_tp && !prev_tx) begin
                if (q.size() == 0) begin
                    chk("unexpected_grant", {62'd0, grant_id}, 64'd3);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("grant_id", {62'd0, grant_id}, {62'd0, e.id});
                    chk("grant_hdr", {28'd0, tx_hdr}, {28'd0, e.hdr});
                    last_id = e.id;
                end
            end
            if (acks != 3'b000) begin
                n_acks++;
                chk("ack_excl", {61'd0, acks}, {61'd0, 3'b001 << last_id});
                chk("ack_width", {61'd0, acks & prev_ack}, 64'd0);
            end
            prev_tx  = tx_tp;
            prev_ack = acks;
        end
    end

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    task automatic wait_tx(input int bound, output int cnt);
        cnt = 0;
        while (!tx_tp && cnt < bound) begin
            tick();
            cnt++;
        end
        if (!tx_tp) chk("tx_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic link_ack(input int dly);
        repeat (dly) tick();
        tx_tp_ack = 1'b1;
        tick();
        tx_tp_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {req_a, req_b, req_c} = 3'b000;
        tx_tp_ack = 1'b0;
        link_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic grant_one(input logic [2:0] r, input int dly);
        int c;
        {req_c, req_b, req_a} = r;
        wait_tx(20, c);
        link_ack(dly);
        {req_c, req_b, req_a} = 3'b000;
        repeat (3) tick();
    endtask

    initial begin
        hdr_a = HA;
        hdr_b = HB;
        hdr_c = HC;
        tick();
        chk("rst_tx", {63'd0, tx_tp}, 64'd0);
        chk("rst_gid", {62'd0, grant_id}, 64'd3);
        chk("rst_hdr", {28'd0, tx_hdr}, 64'd0);
        chk("rst_err", {62'd0, err_timeout, err_drop}, 64'd0);
        chk("rst_ack", {61'd0, acks}, 64'd0);
        reset = 1'b0;

        // single request, ack 3 cycles after tx_tp rises, header change ignored
        q.push_back('{2'd0, HA});
        req_a = 1'b1;
        wait_tx(20, n);
        chk("latency", n, 1);
        hdr_a = ~HA;
        tick();
        chk("hdr_held", {28'd0, tx_hdr}, {28'd0, HA});
        link_ack(2);
        chk("done_tx", {63'd0, tx_tp}, 64'd0);
        chk("done_ack", {61'd0, acks}, 64'd1);
        chk("done_gid", {62'd0, grant_id}, 64'd3);
        hdr_a = HA;
        q.push_back('{2'd0, HA});
        wait_tx(20, n);
        chk("gap_regrant", n, 3);
        link_ack(0);
        req_a = 1'b0;
        repeat (3) tick();

        // all three held continuously
        do_reset();
        for (int i = 0; i < 6; i++) q.push_back('{2'(i % 3), (i % 3 == 0) ? HA : (i % 3 == 1) ? HB : HC});
        {req_a, req_b, req_c} = 3'b111;
        for (int i = 0; i < 6; i++) begin
            wait_tx(20, n);
            link_ack(1);
        end
        {req_a, req_b, req_c} = 3'b000;
        repeat (4) tick();
        chk("rr_drained", q.size(), 0);

        // fairness
        q.push_back('{2'd0, HA});
        grant_one(3'b001, 0);
        q.push_back('{2'd1, HB});
        grant_one(3'b011, 0);
        q.push_back('{2'd2, HC});
        grant_one(3'b100, 0);
        q.push_back('{2'd0, HA});
        grant_one(3'b101, 0);

        // timeout on C, then re-grant
        q.push_back('{2'd2, HC});
        req_c = 1'b1;
        wait_tx(20, n);
        n = 0;
        begin
            int a0;
            a0 = n_acks;
            while (tx_tp && n < 1100) begin
                tick();
                n++;
            end
            chk("to_len", n, 1023);
            chk("to_err", {62'd0, err_timeout, err_drop}, 64'b10);
            chk("to_no_ack", n_acks - a0, 0);
        end
        q.push_back('{2'd2, HC});
        wait_tx(20, n);
        chk("to_regrant", n, 3);
        link_ack(0);
        req_c = 1'b0;
        repeat (3) tick();

        // link drop during ISSUE
        do_reset();
        q.push_back('{2'd0, HA});
        req_a = 1'b1;
        wait_tx(20, n);
        tick();
        link_ready = 1'b0;
        tick();
        chk("drop_tx", {63'd0, tx_tp}, 64'd0);
        chk("drop_err", {62'd0, err_timeout, err_drop}, 64'b11);
        repeat (10) tick();
        chk("down_no_grant", {63'd0, tx_tp}, 64'd0);
        q.push_back('{2'd0, HA});
        link_ready = 1'b1;
        wait_tx(10, n);
        chk("up_grant", n, 1);
        link_ack(0);
        req_a = 1'b0;
        repeat (3) tick();

        // ack coincident with timeout
        do_reset();
        q.push_back('{2'd0, HA});
        req_a = 1'b1;
        wait_tx(20, n);
        repeat (1022) tick();
        chk("late_tx", {63'd0, tx_tp}, 64'd1);
        link_ack(0);
        chk("coin_ack", {61'd0, acks}, 64'd1);
        chk("coin_err", {63'd0, err_timeout}, 64'd0);
        req_a = 1'b0;
        repeat (3) tick();

        // reset mid-ISSUE
        q.push_back('{2'd1, HB});
        req_b = 1'b1;
        wait_tx(20, n);
        tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_tx", {63'd0, tx_tp}, 64'd0);
        tick();
        q.push_back('{2'd0, HA});
        {req_a, req_b} = 2'b11;
        reset = 1'b0;
        wait_tx(20, n);
        link_ack(0);
        {req_a, req_b} = 2'b00;
        repeat (4) tick();
        chk("sb_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/usb3_tp_arbiter.md
Name: usb3_tp_arbiter

Overview:
Shares the link layer's single transaction-packet (TP) transmit port between three protocol-layer TP sources: A (data ACK), B (status ACK) and C (NRDY/ERDY). It runs a round-robin scheduler over level requests and holds the winner's header stable to the link until the link accepts it. It returns a one-cycle ack to the winning source. It also gates transmission on link readiness, aborts stalled transmits, and keeps sticky error flags.

Parameters:
TIMEOUT, 1023, cycles in ISSUE without tx_tp_ack before abort (counter 10 bits, fixed width)
HOLDOFF, 2, dead cycles after each completed or aborted grant; covers the one extra cycle a registered requester keeps its request high

Ports:
local_clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
link_ready  in  1  high while LTSSM is in U0
req_a / req_b / req_c  in  1 each  level request; held with header until ack
hdr_a / hdr_b / hdr_c  in  36 each  {retry, dir, subtype[3:0], endp[3:0], nump[4:0], seq[4:0], stream[15:0]}, MSB first
ack_a / ack_b / ack_c  out  1 each  one-cycle grant-complete pulse
tx_tp  out  1  TP send request to link
tx_tp_retry, tx_tp_dir  out  1 each  latched header fields
tx_tp_subtype, tx_tp_endp  out  4 each  latched header fields
tx_tp_nump, tx_tp_seq  out  5 each  latched header fields
tx_tp_stream  out  16  latched header field
tx_tp_ack  in  1  link accepted the TP
grant_id  out  2  0=A, 1=B, 2=C, 3=none
err_timeout  out  1  sticky; set on any abort
err_drop  out  1  sticky; a request was pending when link_ready fell

Behaviour:
- Reset values: tx_tp=0, all header outputs 0, ack_*=0, grant_id=3, err_*=0, state=IDLE, last_winner=C (first scan order A,B,C), counters 0. Reset mid-operation drops tx_tp immediately with no ack.
- States: IDLE, ISSUE, GAP.
- IDLE:
  - Requires link_ready=1 and any req_* high.
  - Winner is the first requester after last_winner in the cyclic order A→B→C→A.
  - Registers the winner's hdr into the tx_tp_* outputs and sets tx_tp=1 and grant_id.
  - Resets the timeout counter and enters ISSUE.
  - Latency: request sampled at edge k gives tx_tp high in cycle k+1.
- ISSUE:
  - tx_tp and header are held constant; later hdr changes are ignored. Counter increments each cycle.
  - tx_tp_ack=1: tx_tp←0, ack_<winner>←1 for exactly the next cycle, last_winner←winner, grant_id←3, enter GAP with count HOLDOFF.
  - Abort, no ack pulse: counter reaches TIMEOUT, or link_ready=0.
    - tx_tp←0, err_timeout←1, last_winner←winner (prevents starvation lock), enter GAP.
    - err_drop←1 additionally if link_ready=0.
  - If tx_tp_ack and the abort condition occur in the same cycle, the ack wins: normal completion, no error.
- GAP:
  - No grants; decrement count; return to IDLE when the count reaches 0.
  - HOLDOFF=0 returns to IDLE on the next cycle.
- Requests while link_ready=0 in IDLE: not granted and not errors. They wait.
- Requests are never queued. A requester that drops req before grant loses its slot silently.
- ack_* are mutually exclusive. At most one TP is in flight.
- Header fields pass through bit-exact, with no arithmetic on them.

Test Plan:
- Single request: req_a=1, hdr_a with subtype=ACK(1), endp=2, nump=1, seq=5, retry=0; link acks 3 cycles after tx_tp rises → tx_tp fields equal hdr_a, ack_a pulses 1 cycle, tx_tp low, 2 GAP cycles, grant_id=3.
- Simultaneous A,B,C held continuously, link acks each after 1 cycle → grant order A,B,C,A,B,C; each ack_* is a single cycle; no overlap.
- Fairness: after A wins, B and A request together → B granted next; then C only → C; then A and C → A.
- Timeout: req_c=1, link never acks → tx_tp drops after 1023 ISSUE cycles; err_timeout=1; ack_c never pulses; after GAP, C is re-granted (sole requester).
- Link down: tx_tp high, link_ready falls → tx_tp=0 next cycle; err_timeout=1 and err_drop=1; no grants while link_ready=0; grant resumes after it rises.
- Ack coincident with timeout at cycle 1023 → ack pulse issued; err_timeout stays 0. Assert reset mid-ISSUE → tx_tp=0 immediately; after release, order restarts at A.
